// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load/data-hazard stalls, branch wait/flush FSM and a saturating stall counter.
// Define HAZARD_CTRL_FWD_EN to enable EX/MEM and MEM/WB forwarding (only load-use then stalls).
module hazard_ctrl #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [6:0]        opcode,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd_id_ex,
  input  logic [ADDR_W-1:0] rd_ex_mem,
  input  logic [ADDR_W-1:0] rd_mem_wb,
  input  logic              regwrite_id_ex,
  input  logic              regwrite_ex_mem,
  input  logic              regwrite_mem_wb,
  input  logic              memread_id_ex,
  input  logic              branch_resolved,
  input  logic              branch_taken,
  output logic              pc_load,
  output logic              if_id_load,
  output logic              id_ex_bubble,
  output logic              if_id_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_count,
  output logic [1:0]        state_dbg
);

  // state_dbg encoding: 0 RUN, 1 BR_WAIT, 2 FLUSH.
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    BR_WAIT = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_SB    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state, state_next;

  logic rs1_used, rs2_used, is_sb;
  logic m1_id_ex, m1_ex_mem, m1_mem_wb;
  logic m2_id_ex, m2_ex_mem, m2_mem_wb;
  logic data_hazard;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  assign rs1_used = (opcode == OP_R) || (opcode == OP_S) || (opcode == OP_SB) ||
                    (opcode == OP_LOAD) || (opcode == OP_IALU) || (opcode == OP_JALR);
  assign rs2_used = (opcode == OP_R) || (opcode == OP_S) || (opcode == OP_SB);
  assign is_sb    = (opcode == OP_SB);

  // A qualified match: register read, nonzero, equal to the stage rd, and that stage writes.
  assign m1_id_ex  = rs1_used && (rs1 != '0) && (rs1 == rd_id_ex)  && regwrite_id_ex;
  assign m1_ex_mem = rs1_used && (rs1 != '0) && (rs1 == rd_ex_mem) && regwrite_ex_mem;
  assign m1_mem_wb = rs1_used && (rs1 != '0) && (rs1 == rd_mem_wb) && regwrite_mem_wb;
  assign m2_id_ex  = rs2_used && (rs2 != '0) && (rs2 == rd_id_ex)  && regwrite_id_ex;
  assign m2_ex_mem = rs2_used && (rs2 != '0) && (rs2 == rd_ex_mem) && regwrite_ex_mem;
  assign m2_mem_wb = rs2_used && (rs2 != '0) && (rs2 == rd_mem_wb) && regwrite_mem_wb;

`ifdef HAZARD_CTRL_FWD_EN
  assign data_hazard = memread_id_ex && (m1_id_ex || m2_id_ex);
  assign fwd_a_raw   = m1_ex_mem ? 2'b10 : (m1_mem_wb ? 2'b01 : 2'b00);
  assign fwd_b_raw   = m2_ex_mem ? 2'b10 : (m2_mem_wb ? 2'b01 : 2'b00);
`else
  logic unused_memread;
  assign unused_memread = memread_id_ex;
  assign data_hazard = m1_id_ex || m1_ex_mem || m1_mem_wb ||
                       m2_id_ex || m2_ex_mem || m2_mem_wb;
  assign fwd_a_raw   = 2'b00;
  assign fwd_b_raw   = 2'b00;
`endif

  assign fwd_a     = reset ? 2'b00 : fwd_a_raw;
  assign fwd_b     = reset ? 2'b00 : fwd_b_raw;
  assign state_dbg = state;

  always_ff @(posedge clock) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    pc_load      = 1'b1;
    if_id_load   = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    case (state)
      RUN: begin
        // A data hazard outranks a branch: the branch waits in ID until operands are safe.
        if (data_hazard) begin
          pc_load      = 1'b0;
          if_id_load   = 1'b0;
          id_ex_bubble = 1'b1;
        end else if (is_sb) begin
          pc_load    = 1'b0;
          state_next = BR_WAIT;
        end
      end
      BR_WAIT: begin
        id_ex_bubble = 1'b1;
        if (!branch_resolved) begin
          pc_load    = 1'b0;
          if_id_load = 1'b0;
        end else begin
          state_next = branch_taken ? FLUSH : RUN;
        end
      end
      FLUSH: begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        state_next   = RUN;
      end
      default: state_next = RUN;
    endcase
    if (reset) begin
      pc_load      = 1'b0;
      if_id_load   = 1'b0;
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      stall_count <= '0;
    else if (!pc_load && (stall_count != CNT_MAX))
      stall_count <= stall_count + CNT_ONE;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter ADDR_W, default 5, register-address width.
REQ-002 Parameter CNT_W, default 16, stall-counter width.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clock  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 opcode  in  7  opcode of the instruction in ID.
REQ-007 rs1, rs2  in  ADDR_W  source registers of the ID instruction.
REQ-008 rd_id_ex, rd_ex_mem, rd_mem_wb  in  ADDR_W  destination registers in ID/EX, EX/MEM and MEM/WB.
REQ-009 regwrite_id_ex, regwrite_ex_mem, regwrite_mem_wb  in  1  write-enable of each destination.
REQ-010 memread_id_ex  in  1  ID/EX holds a load.
REQ-011 branch_resolved  in  1  EX has resolved the branch this cycle.
REQ-012 branch_taken  in  1  resolution outcome; valid only with branch_resolved.
REQ-013 pc_load  out  1  PC write enable.
REQ-014 if_id_load  out  1  IF/ID write enable.
REQ-015 id_ex_bubble  out  1  inserts a NOP into ID/EX.
REQ-016 if_id_flush  out  1  clears IF/ID.
REQ-017 fwd_a, fwd_b  out  2  forwarding select for rs1 and rs2: 00 regfile, 10 EX/MEM, 01 MEM/WB.
REQ-018 stall_count  out  CNT_W  count of cycles with pc_load=0.

Function
REQ-019 Register-use decode:
- rs1 is used by R 0110011, S 0100011, SB 1100011, LOAD 0000011, I-ALU 0010011 and JALR 1100111.
- rs2 is used by R, S and SB.
REQ-020 A match is qualified by: the source register is used, the source register is nonzero, it equals the stage rd, and that stage's regwrite is 1.
REQ-021 The FSM has three states: RUN, BR_WAIT and FLUSH.
REQ-022 RUN with data hazard: pc_load=0, if_id_load=0, id_ex_bubble=1; the FSM stays in RUN.
REQ-023 RUN, no hazard, opcode=SBTYPE: pc_load=0, if_id_load=1, id_ex_bubble=0; next state is BR_WAIT.
REQ-024 RUN, no hazard, other opcode: pc_load=1, if_id_load=1, id_ex_bubble=0, if_id_flush=0.
REQ-025 When a data hazard and SBTYPE coincide in RUN, the data hazard has priority; the FSM does not enter BR_WAIT until the hazard clears.
REQ-026 BR_WAIT with branch_resolved=0: pc_load=0, if_id_load=0, id_ex_bubble=1; the FSM stays in BR_WAIT indefinitely.
REQ-027 BR_WAIT with branch_resolved=1: pc_load=1, if_id_load=1, id_ex_bubble=1; next state is FLUSH if branch_taken=1, otherwise RUN.
REQ-028 FLUSH lasts exactly one cycle: if_id_flush=1, id_ex_bubble=1, pc_load=1, if_id_load=1; next state is RUN.
REQ-029 if_id_flush is 1 only in FLUSH.
REQ-030 Outputs are combinational from the state and the current inputs; the FSM transition takes one cycle.
REQ-031 stall_count increments on every clock edge where pc_load=0, saturates at 2^CNT_W-1, and never wraps.

Reset
REQ-032 On reset, the FSM goes to RUN and stall_count goes to 0 on the next clock edge, including when reset is asserted during BR_WAIT or FLUSH.
REQ-033 While reset=1, outputs are: pc_load=0, if_id_load=0, id_ex_bubble=1, if_id_flush=0, fwd_a=fwd_b=00.

Configuration
REQ-034 Macro HAZARD_CTRL_FWD_EN selects the forwarding feature.
REQ-035 With HAZARD_CTRL_FWD_EN defined:
- A data hazard is load-use only: memread_id_ex=1 and a qualified rs1/rs2 match on rd_id_ex.
- fwd_a/fwd_b select 10 on a qualified match with EX/MEM, else 01 on a match with MEM/WB, else 00; EX/MEM has priority.
REQ-036 Without HAZARD_CTRL_FWD_EN:
- A data hazard is any qualified rs1/rs2 match against the ID/EX, EX/MEM or MEM/WB destination.
- fwd_a and fwd_b are tied to 00.
- The port list is unchanged.

Verification
REQ-037 Without FWD_EN: opcode=0110011, rs1=3, rd_ex_mem=3, regwrite_ex_mem=1 -> pc_load=0, if_id_load=0, id_ex_bubble=1; stall_count increments by 1 per cycle.
REQ-038 With FWD_EN, same stimulus as REQ-037 -> no stall and fwd_a=10. Then memread_id_ex=1, rd_id_ex=3 -> stall for exactly the cycles the condition holds.
REQ-039 opcode=1100011, no hazard -> RUN to BR_WAIT. Hold branch_resolved=0 for 3 cycles, then assert it with branch_taken=1 -> FLUSH for 1 cycle with if_id_flush=1, then RUN. stall_count=4.
REQ-040 Same as REQ-039 with branch_taken=0 -> return to RUN directly; if_id_flush is never 1.
REQ-041 Reset asserted for 1 cycle while in BR_WAIT -> state RUN and stall_count=0 on the next edge. rs1=0 with rd_ex_mem=0 and regwrite=1 -> no hazard.
REQ-042 With CNT_W=4, force 20 stall cycles -> stall_count=15 and holds at 15.
